// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-master to one-slave memory arbiter. The data cache (dc_*) and the
//   instruction cache (ic_*) each issue single-cycle request strobes. Each
//   strobe is captured into a per-master request slot. Requests are
//   serialised onto a single memory port with round-robin priority, and the
//   memory request is held at level until memory accepts it.
//
// Ports
//   clk, reset      : single rising-edge clock, synchronous active-high reset
//   ic_addr/ic_ren  : icache read request (the icache only reads)
//   ic_rdata/ready  : icache read data, valid with the one-cycle ic_ready pulse
//   dc_addr/wdata   : dcache request address and write data
//   dc_wen/dc_ren   : dcache write / read strobe (a write wins if both are set)
//   dc_rdata/ready  : dcache read data, valid with the one-cycle dc_ready pulse
//   mem_addr/wdata  : memory address and write data, held while a request is open
//   mem_wen/mem_ren : memory write / read request, held until mem_ready
//   mem_rdata/ready : memory read data and one-cycle completion

module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  input  logic                  ic_ren,
  output logic [DATA_WIDTH-1:0] ic_rdata,
  output logic                  ic_ready,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [DATA_WIDTH-1:0] dc_wdata,
  input  logic                  dc_wen,
  input  logic                  dc_ren,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  output logic                  dc_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {MST_IC, MST_DC} master_t;

  state_t  state;
  master_t grant;
  master_t last_grant;

  // Request slots
  logic                  ic_valid;
  logic [ADDR_WIDTH-1:0] ic_addr_q;
  logic                  dc_valid;
  logic [ADDR_WIDTH-1:0] dc_addr_q;
  logic [DATA_WIDTH-1:0] dc_wdata_q;
  logic                  dc_write_q;

  // Arbitration
  logic                  ic_take;
  logic                  dc_strobe;
  logic                  dc_take;
  logic                  ic_elig;
  logic                  dc_elig;
  logic                  pick_dc;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_write;

  always_comb begin
    ic_take   = !ic_valid && ic_ren;
    dc_strobe = dc_wen || dc_ren;
    dc_take   = !dc_valid && dc_strobe;

    // A slot stays occupied through its ready cycle and frees on the edge
    // after it. During that cycle it must not compete again, so a
    // completing slot is not eligible.
    ic_elig = (ic_valid && !ic_ready) || ic_take;
    dc_elig = (dc_valid && !dc_ready) || dc_take;

    // On a tie the grant goes to the master that was not served last.
    pick_dc = dc_elig && (!ic_elig || (last_grant == MST_IC));

    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    if (pick_dc) begin
      // A request arriving this cycle bypasses its (empty) slot.
      sel_write = dc_valid ? dc_write_q : dc_wen;
      sel_addr  = dc_valid ? dc_addr_q : dc_addr;
      if (sel_write) begin
        sel_wdata = dc_valid ? dc_wdata_q : dc_wdata;
      end
    end else begin
      sel_addr = ic_valid ? ic_addr_q : ic_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= MST_IC;
      last_grant <= MST_IC;
      ic_valid   <= 1'b0;
      ic_addr_q  <= '0;
      dc_valid   <= 1'b0;
      dc_addr_q  <= '0;
      dc_wdata_q <= '0;
      dc_write_q <= 1'b0;
      ic_rdata   <= '0;
      ic_ready   <= 1'b0;
      dc_rdata   <= '0;
      dc_ready   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wen    <= 1'b0;
      mem_ren    <= 1'b0;
    end else begin
      ic_ready <= 1'b0;
      dc_ready <= 1'b0;

      // Slot capture and release. A slot can only be captured while it is
      // empty and only released during its ready cycle (when it is
      // occupied), so the two never coincide.
      if (ic_take) begin
        ic_valid  <= 1'b1;
        ic_addr_q <= ic_addr;
      end else if (ic_ready) begin
        ic_valid <= 1'b0;
      end

      if (dc_take) begin
        dc_valid   <= 1'b1;
        dc_addr_q  <= dc_addr;
        dc_wdata_q <= dc_wdata;
        dc_write_q <= dc_wen;
      end else if (dc_ready) begin
        dc_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ic_elig || dc_elig) begin
            grant     <= pick_dc ? MST_DC : MST_IC;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_wen   <= sel_write;
            mem_ren   <= !sel_write;
            state     <= BUSY;
          end
        end

        BUSY: begin
          if (mem_ready) begin
            mem_wen    <= 1'b0;
            mem_ren    <= 1'b0;
            last_grant <= grant;
            state      <= IDLE;
            if (grant == MST_DC) begin
              dc_ready <= 1'b1;
              if (mem_ren) begin
                dc_rdata <= mem_rdata;
              end
            end else begin
              ic_ready <= 1'b1;
              ic_rdata <= mem_rdata;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
  logic        ic_ren, dc_wen, dc_ren, mem_ready;
  logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
  logic        ic_ready, dc_ready, mem_wen, mem_ren;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .ic_addr(ic_addr), .ic_ren(ic_ren), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wen(dc_wen), .dc_ren(dc_ren),
    .dc_rdata(dc_rdata), .dc_ready(dc_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // One record per clock cycle: inputs driven during the cycle and the
  // outputs expected during that same cycle.
  typedef struct {
    logic        rst;
    logic        icr;
    logic [31:0] ica;
    logic        dcr;
    logic        dcw;
    logic [31:0] dca;
    logic [31:0] dcwd;
    logic        mrdy;
    logic [31:0] mrd;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        e_icr;
    logic        e_dcr;
    logic [31:0] e_icd;
    logic [31:0] e_dcd;
    logic        e_zero;
  } vec_t;

  function automatic vec_t v(
    logic rst, logic icr, logic [31:0] ica, logic dcr, logic dcw,
    logic [31:0] dca, logic [31:0] dcwd, logic mrdy, logic [31:0] mrd,
    logic e_ren, logic e_wen, logic [31:0] e_addr, logic [31:0] e_wd,
    logic e_icr, logic e_dcr, logic [31:0] e_icd, logic [31:0] e_dcd, logic e_zero);
    vec_t r;
    r.rst = rst; r.icr = icr; r.ica = ica; r.dcr = dcr; r.dcw = dcw;
    r.dca = dca; r.dcwd = dcwd; r.mrdy = mrdy; r.mrd = mrd;
    r.e_ren = e_ren; r.e_wen = e_wen; r.e_addr = e_addr; r.e_wd = e_wd;
    r.e_icr = e_icr; r.e_dcr = e_dcr; r.e_icd = e_icd; r.e_dcd = e_dcd;
    r.e_zero = e_zero;
    return r;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    reset = 1'b0; ic_ren = 1'b0; ic_addr = '0; dc_ren = 1'b0; dc_wen = 1'b0;
    dc_addr = '0; dc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
  endtask

  vec_t vecs[39];

  initial begin
    localparam logic [31:0] D = 32'hDEAD_BEEF;
    localparam logic [31:0] A = 32'hAAAA_0000;
    localparam logic [31:0] B = 32'hBBBB_0000;
    localparam logic [31:0] C1 = 32'h1111_0000;
    localparam logic [31:0] C2 = 32'h2222_0000;
    localparam logic [31:0] C4 = 32'h4444_0000;
    int found;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;

    // Single read with three wait states
    vecs[0]  = v(0,0,0,     1,0,'h100,0,          0,0,           0,0,0,0,          0,0,0,0, 1);
    vecs[1]  = v(0,0,0,     0,0,0,0,              0,0,           1,0,'h100,0,      0,0,0,0, 0);
    vecs[2]  = v(0,0,0,     0,0,0,0,              0,0,           1,0,'h100,0,      0,0,0,0, 0);
    vecs[3]  = v(0,0,0,     0,0,0,0,              0,0,           1,0,'h100,0,      0,0,0,0, 0);
    vecs[4]  = v(0,0,0,     0,0,0,0,              1,D,           1,0,'h100,0,      0,0,0,0, 0);
    vecs[5]  = v(0,0,0,     0,0,0,0,              0,0,           0,0,0,0,          0,1,0,D, 0);
    vecs[6]  = v(0,0,0,     0,0,0,0,              0,0,           0,0,0,0,          0,0,0,D, 0);
    // Zero-wait write; read data must not move
    vecs[7]  = v(0,0,0,     0,1,'h200,'h12345678, 0,0,           0,0,0,0,          0,0,0,D, 0);
    vecs[8]  = v(0,0,0,     0,0,0,0,              1,'h55555555,  0,1,'h200,'h12345678, 0,0,0,D, 0);
    vecs[9]  = v(0,0,0,     0,0,0,0,              0,0,           0,0,0,0,          0,1,0,D, 0);
    vecs[10] = v(0,0,0,     0,0,0,0,              0,0,           0,0,0,0,          0,0,0,D, 0);
    // Simultaneous requests after reset: DC first
    vecs[11] = v(1,0,0,     0,0,0,0,              0,0,           0,0,0,0,          0,0,0,D, 0);
    vecs[12] = v(0,1,'h40,  1,0,'h80,0,           0,0,           0,0,0,0,          0,0,0,0, 1);
    vecs[13] = v(0,0,0,     0,0,0,0,              0,0,           1,0,'h80,0,       0,0,0,0, 0);
    vecs[14] = v(0,0,0,     0,0,0,0,              1,B,           1,0,'h80,0,       0,0,0,0, 0);
    vecs[15] = v(0,0,0,     0,0,0,0,              0,0,           0,0,0,0,          0,1,0,B, 0);
    vecs[16] = v(0,0,0,     0,0,0,0,              0,0,           1,0,'h40,0,       0,0,0,B, 0);
    vecs[17] = v(0,0,0,     0,0,0,0,              1,A,           1,0,'h40,0,       0,0,0,B, 0);
    vecs[18] = v(0,0,0,     0,0,0,0,              0,0,           0,0,0,0,          1,0,A,B, 0);
    vecs[19] = v(0,0,0,     0,0,0,0,              0,0,           0,0,0,0,          0,0,A,B, 0);
    // IC strobes during a DC transaction; second one and ready-cycle one dropped
    vecs[20] = v(0,0,0,     1,0,'h300,0,          0,0,           0,0,0,0,          0,0,A,B, 0);
    vecs[21] = v(0,1,'h500, 0,0,0,0,              0,0,           1,0,'h300,0,      0,0,A,B, 0);
    vecs[22] = v(0,1,'h600, 0,0,0,0,              0,0,           1,0,'h300,0,      0,0,A,B, 0);
    vecs[23] = v(0,0,0,     0,0,0,0,              1,C1,          1,0,'h300,0,      0,0,A,B, 0);
    vecs[24] = v(0,0,0,     0,0,0,0,              0,0,           0,0,0,0,          0,1,A,C1, 0);
    vecs[25] = v(0,0,0,     0,0,0,0,              0,0,           1,0,'h500,0,      0,0,A,C1, 0);
    vecs[26] = v(0,0,0,     0,0,0,0,              1,C2,          1,0,'h500,0,      0,0,A,C1, 0);
    vecs[27] = v(0,1,'h700, 0,0,0,0,              0,0,           0,0,0,0,          1,0,C2,C1, 0);
    vecs[28] = v(0,0,0,     0,0,0,0,              0,0,           0,0,0,0,          0,0,C2,C1, 0);
    vecs[29] = v(0,0,0,     0,0,0,0,              0,0,           0,0,0,0,          0,0,C2,C1, 0);
    // Reset during BUSY, mem_ready arriving afterwards
    vecs[30] = v(0,0,0,     1,0,'h900,0,          0,0,           0,0,0,0,          0,0,C2,C1, 0);
    vecs[31] = v(1,0,0,     0,0,0,0,              0,0,           1,0,'h900,0,      0,0,C2,C1, 0);
    vecs[32] = v(0,0,0,     0,0,0,0,              1,'h33330000,  0,0,0,0,          0,0,0,0, 1);
    vecs[33] = v(0,0,0,     0,0,0,0,              0,0,           0,0,0,0,          0,0,0,0, 1);
    vecs[34] = v(0,0,0,     1,0,'hA00,0,          0,0,           0,0,0,0,          0,0,0,0, 0);
    vecs[35] = v(0,0,0,     0,0,0,0,              0,0,           1,0,'hA00,0,      0,0,0,0, 0);
    vecs[36] = v(0,0,0,     0,0,0,0,              1,C4,          1,0,'hA00,0,      0,0,0,0, 0);
    vecs[37] = v(0,0,0,     0,0,0,0,              0,0,           0,0,0,0,          0,1,0,C4, 0);
    vecs[38] = v(0,0,0,     0,0,0,0,              0,0,           0,0,0,0,          0,0,0,C4, 0);

    // Reset state
    drive_idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mem_ren",   -1, {31'd0, mem_ren}, 32'd0);
    chk("rst_mem_wen",   -1, {31'd0, mem_wen}, 32'd0);
    chk("rst_mem_addr",  -1, mem_addr, 32'd0);
    chk("rst_mem_wdata", -1, mem_wdata, 32'd0);
    chk("rst_ic_ready",  -1, {31'd0, ic_ready}, 32'd0);
    chk("rst_dc_ready",  -1, {31'd0, dc_ready}, 32'd0);
    chk("rst_ic_rdata",  -1, ic_rdata, 32'd0);
    chk("rst_dc_rdata",  -1, dc_rdata, 32'd0);

    // Table-driven cycles
    for (int i = 0; i < 39; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; ic_ren = vecs[i].icr; ic_addr = vecs[i].ica;
      dc_ren = vecs[i].dcr; dc_wen = vecs[i].dcw; dc_addr = vecs[i].dca;
      dc_wdata = vecs[i].dcwd; mem_ready = vecs[i].mrdy; mem_rdata = vecs[i].mrd;
      #1;
      chk("mem_ren",  i, {31'd0, mem_ren},  {31'd0, vecs[i].e_ren});
      chk("mem_wen",  i, {31'd0, mem_wen},  {31'd0, vecs[i].e_wen});
      chk("ic_ready", i, {31'd0, ic_ready}, {31'd0, vecs[i].e_icr});
      chk("dc_ready", i, {31'd0, dc_ready}, {31'd0, vecs[i].e_dcr});
      chk("ic_rdata", i, ic_rdata, vecs[i].e_icd);
      chk("dc_rdata", i, dc_rdata, vecs[i].e_dcd);
      if (vecs[i].e_ren || vecs[i].e_wen || vecs[i].e_zero) begin
        chk("mem_addr",  i, mem_addr,  vecs[i].e_addr);
        chk("mem_wdata", i, mem_wdata, vecs[i].e_wd);
      end
    end

    // Both masters requesting continuously: grants must alternate DC, IC, ...
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ic_ren = 1'b1; ic_addr = 32'h1000;
    dc_ren = 1'b1; dc_addr = 32'h2000;
    for (int k = 0; k < 6; k++) begin
      found = 0;
      for (int w = 0; w < 20 && found == 0; w++) begin
        @(negedge clk);
        #1;
        if (mem_ren) found = 1;
      end
      chk("rr_grant_seen", k, found, 1);
      exp_addr = (k % 2 == 0) ? 32'h2000 : 32'h1000;
      exp_data = 32'hC0DE_0000 + k;
      chk("rr_order_addr", k, mem_addr, exp_addr);
      mem_ready = 1'b1;
      mem_rdata = exp_data;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = '0;
      #1;
      chk("rr_dc_ready", k, {31'd0, dc_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ic_ready", k, {31'd0, ic_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k % 2 == 0) chk("rr_dc_rdata", k, dc_rdata, exp_data);
      else            chk("rr_ic_rdata", k, ic_rdata, exp_data);
    end
    drive_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
